mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 17 +
 rtl/rr_arb2.sv | 17 +
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter.
//   DefWidth     : default data word width
//   DefAddrWidth : default memory address width
//   state_e      : 2-bit arbiter FSM encoding, fixed order IDLE, ACCESS, WAIT, ACK
package mem_arbiter_pkg;

  localparam int unsigned DefWidth     = 32;
  localparam int unsigned DefAddrWidth = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StWait   = 2'd2,
    StAck    = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant selection, purely combinational.
//   req0, req1 : pending requests
//   last       : requester granted most recently (0 or 1)
//   gnt0, gnt1 : one-hot grant (both low when nothing is requested)
module rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1
);

  // On a tie the requester that was not served last wins.
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous memory between a core (requester 0)
// and a DMA engine (requester 1). Each access takes IDLE -> ACCESS -> WAIT -> ACK.
//   clk, rst                    : clock, asynchronous active-low reset
//   reqN_i/weN_i/addrN_i/wdataN_i : request, direction, address, write data per requester
//   ackN_o                      : one-cycle completion pulse
//   rdataN_o                    : last read data returned to requester N
//   memread_o/memwrite_o        : memory strobes, only asserted in ACCESS
//   memaddr_o/memwdata_o        : memory address / write data, zero outside ACCESS
//   memrdata_i                  : memory read data, valid the cycle after memread_o
//   busy_o                      : high whenever the FSM is not idle
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = DefWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [WIDTH-1:0]      wdata0_i,
  input  logic [WIDTH-1:0]      wdata1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic [WIDTH-1:0]      rdata0_o,
  output logic [WIDTH-1:0]      rdata1_o,
  output logic                  memread_o,
  output logic                  memwrite_o,
  output logic [ADDR_WIDTH-1:0] memaddr_o,
  output logic [WIDTH-1:0]      memwdata_o,
  input  logic [WIDTH-1:0]      memrdata_i,
  output logic                  busy_o
);

  state_e                state_q, state_d;
  logic                  winner_q, winner_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      wdata_q, wdata_d;
  logic                  last_q, last_d;
  logic [WIDTH-1:0]      rdata0_q, rdata0_d;
  logic [WIDTH-1:0]      rdata1_q, rdata1_d;
  logic                  gnt0, gnt1;

  rr_arb2 u_rr_arb2 (
    .req0 (req0_i),
    .req1 (req1_i),
    .last (last_q),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    last_d   = last_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      StIdle: begin
        if (gnt0 | gnt1) begin
          state_d  = StAccess;
          winner_d = gnt1;
          last_d   = gnt1;
          we_d     = gnt1 ? we1_i    : we0_i;
          addr_d   = gnt1 ? addr1_i  : addr0_i;
          wdata_d  = gnt1 ? wdata1_i : wdata0_i;
        end
      end
      StAccess: state_d = StWait;
      StWait: begin
        // Memory data for the ACCESS-cycle read is present now; capture it on this edge.
        if (!we_q) begin
          if (winner_q) rdata1_d = memrdata_i;
          else          rdata0_d = memrdata_i;
        end
        state_d = StAck;
      end
      // Requests are ignored here so a requester that re-raises right after ack waits a turn.
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      winner_q <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      last_q   <= 1'b1;  // requester 0 wins the first tie
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      last_q   <= last_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    memread_o  = 1'b0;
    memwrite_o = 1'b0;
    memaddr_o  = '0;
    memwdata_o = '0;
    ack0_o     = 1'b0;
    ack1_o     = 1'b0;
    if (state_q == StAccess) begin
      memread_o  = ~we_q;
      memwrite_o = we_q;
      memaddr_o  = addr_q;
      memwdata_o = wdata_q;
    end
    if (state_q == StAck) begin
      ack0_o = ~winner_q;
      ack1_o = winner_q;
    end
  end

  assign busy_o   = (state_q != StIdle);
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter: a transaction-level model predicts every output per cycle.
module tb_mem_arbiter;

  localparam int W  = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_i, req1_i, we0_i, we1_i;
  logic [AW-1:0] addr0_i, addr1_i;
  logic [W-1:0]  wdata0_i, wdata1_i;
  logic          ack0_o, ack1_o;
  logic [W-1:0]  rdata0_o, rdata1_o;
  logic          memread_o, memwrite_o;
  logic [AW-1:0] memaddr_o;
  logic [W-1:0]  memwdata_o;
  logic [W-1:0]  memrdata_i;
  logic          busy_o;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_i     (req0_i),
    .req1_i     (req1_i),
    .we0_i      (we0_i),
    .we1_i      (we1_i),
    .addr0_i    (addr0_i),
    .addr1_i    (addr1_i),
    .wdata0_i   (wdata0_i),
    .wdata1_i   (wdata1_i),
    .ack0_o     (ack0_o),
    .ack1_o     (ack1_o),
    .rdata0_o   (rdata0_o),
    .rdata1_o   (rdata1_o),
    .memread_o  (memread_o),
    .memwrite_o (memwrite_o),
    .memaddr_o  (memaddr_o),
    .memwdata_o (memwdata_o),
    .memrdata_i (memrdata_i),
    .busy_o     (busy_o)
  );

  // Environment: single-port synchronous memory driven by the DUT strobes.
  logic [W-1:0] env_mem [64];
  always @(posedge clk) begin
    if (memwrite_o) env_mem[int'(memaddr_o) % 64] <= memwdata_o;
    if (memread_o)  memrdata_i <= env_mem[int'(memaddr_o) % 64];
  end

  // Requesters
  logic          rq [2];
  logic          rwe [2];
  logic [AW-1:0] raddr [2];
  logic [W-1:0]  rwd [2];
  assign req0_i = rq[0];   assign req1_i = rq[1];
  assign we0_i = rwe[0];   assign we1_i = rwe[1];
  assign addr0_i = raddr[0]; assign addr1_i = raddr[1];
  assign wdata0_i = rwd[0];  assign wdata1_i = rwd[1];

  // Reference model: each grant at edge g owns cycles g (memory strobe), g+1, g+2 (ack);
  // the next grant can happen no earlier than edge g+4.
  logic [W-1:0]  ref_mem [64];
  bit            m_act;
  int            m_g;
  bit            m_win, m_we, m_last;
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_wd, m_rval, m_rd0, m_rd1;
  int            cyc;
  bit            aborted;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_act  = 1'b0;
    m_g    = -100;
    m_last = 1'b1;
    m_rd0  = '0;
    m_rd1  = '0;
  endtask

  task automatic model_edge(input int n);
    if (m_act && n == m_g + 2 && !m_we) begin
      if (m_win) m_rd1 = m_rval;
      else       m_rd0 = m_rval;
    end
    if ((!m_act || n >= m_g + 4) && (rq[0] || rq[1])) begin
      m_win  = (rq[0] && rq[1]) ? !m_last : rq[1];
      m_last = m_win;
      m_we   = rwe[m_win];
      m_addr = raddr[m_win];
      m_wd   = rwd[m_win];
      if (m_we) ref_mem[int'(m_addr)] = m_wd;
      else      m_rval = ref_mem[int'(m_addr)];
      m_g    = n;
      m_act  = 1'b1;
    end
  endtask

  task automatic new_req(input int k, input int pct);
    if ($urandom_range(0, 99) < pct) begin
      rq[k]    = 1'b1;
      rwe[k]   = 1'($urandom_range(0, 1));
      raddr[k] = AW'($urandom_range(0, 63));
      rwd[k]   = $urandom;
    end else begin
      rq[k] = 1'b0;
    end
  endtask

  task automatic drive(input int pct);
    for (int k = 0; k < 2; k++) begin
      bit acked;
      acked = m_act && (cyc - m_g == 2) && (m_win == 1'(k));
      if (!rq[k] || acked) new_req(k, pct);
    end
  endtask

  task automatic check_cycle();
    int ph;
    bit act;
    ph  = m_act ? cyc - m_g : -1;
    act = (ph >= 0 && ph <= 2);
    check_eq("busy",     busy_o,     act);
    check_eq("memread",  memread_o,  ph == 0 && !m_we);
    check_eq("memwrite", memwrite_o, ph == 0 && m_we);
    check_eq("memaddr",  memaddr_o,  (ph == 0) ? m_addr : '0);
    check_eq("memwdata", memwdata_o, (ph == 0) ? m_wd : '0);
    check_eq("ack0",     ack0_o,     ph == 2 && !m_win);
    check_eq("ack1",     ack1_o,     ph == 2 && m_win);
    check_eq("ack_excl", ack0_o & ack1_o, 1'b0);
    check_eq("rdata0",   rdata0_o,   m_rd0);
    check_eq("rdata1",   rdata1_o,   m_rd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"},   busy_o,     1'b0);
    check_eq({tag, "_rd"},     memread_o,  1'b0);
    check_eq({tag, "_wr"},     memwrite_o, 1'b0);
    check_eq({tag, "_addr"},   memaddr_o,  '0);
    check_eq({tag, "_wdata"},  memwdata_o, '0);
    check_eq({tag, "_ack0"},   ack0_o,     1'b0);
    check_eq({tag, "_ack1"},   ack1_o,     1'b0);
    check_eq({tag, "_rdata0"}, rdata0_o,   '0);
    check_eq({tag, "_rdata1"}, rdata1_o,   '0);
  endtask

  // Pulls reset while a read sits in WAIT; the access must vanish without an ack.
  task automatic abort_access();
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    rq[0] = 1'b0;
    rq[1] = 1'b0;
    model_reset();
    @(negedge clk);
    cyc++;
    rst = 1'b1;
    aborted = 1'b1;
  endtask

  task automatic run(input int ncyc, input int pct, input bit abort);
    for (int i = 0; i < ncyc; i++) begin
      drive(pct);
      model_edge(cyc + 1);
      @(negedge clk);
      cyc++;
      check_cycle();
      if (abort && !aborted && m_act && (cyc - m_g == 1) && !m_we) abort_access();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [W-1:0] v;
      v = (i == 'h10) ? 32'hDEAD_BEEF : (32'h1234_5678 ^ (32'(i) * 32'h0101_0101));
      env_mem[i] = v;
      ref_mem[i] = v;
    end
    memrdata_i = '0;
    for (int k = 0; k < 2; k++) begin
      rq[k] = 1'b0; rwe[k] = 1'b0; raddr[k] = '0; rwd[k] = '0;
    end
    cyc     = 0;
    aborted = 1'b0;
    model_reset();

    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Both requesters held continuously from the first cycle: tie goes to 0, then alternates.
    run(40, 100, 1'b0);
    run(300, 50, 1'b0);
    run(400, 60, 1'b1);
    check_eq("abort_reached", aborted, 1'b1);
    run(200, 40, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
